// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
// Byte type, transmit-queue FSM state encoding and the default queue depth.
package uart_pkg;
    typedef logic [7:0] byte_t;
    typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} txq_state_t;
    localparam int UART_TXQ_DEPTH = 16;
endpackage

// File: rtl/uart_tx_fifo_if.sv
// Bundle of the cpu write side, status flags and transmitter handshake of the tx queue.
// master = cpu/transmitter side, slave = the queue itself.
interface uart_tx_fifo_if #(parameter int DEPTH = uart_pkg::UART_TXQ_DEPTH);
    import uart_pkg::*;
    localparam int AW = $clog2(DEPTH);

    logic          wr_req;
    byte_t         wr_data;
    logic          full;
    logic [AW:0]   level;
    logic          overflow;
    logic          ovf_clr;
    logic          send_req;
    byte_t         tx_data;
    logic          busy;

    modport master (
        output wr_req, wr_data, ovf_clr, busy,
        input  full, level, overflow, send_req, tx_data
    );

    modport slave (
        input  wr_req, wr_data, ovf_clr, busy,
        output full, level, overflow, send_req, tx_data
    );
endinterface

// File: rtl/sync_fifo_mem.sv
// DEPTH x 8 storage array: synchronous write, asynchronous read.
// The data array carries no reset; validity is tracked by the pointers in the owner.
module sync_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_TXQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  byte_t         i_wdata,
    input  logic [AW-1:0] i_raddr,
    output byte_t         o_rdata
);
    byte_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit byte queue between the cpu and the UART transmitter.
// Buffers up to DEPTH bytes and hands them out one at a time with a send_req pulse plus busy handshake.
//
//   state   | meaning
//   IDLE    | waiting for a queued byte and an idle transmitter; pops on entry to SEND
//   SEND    | send_req is high this cycle; arm the busy-rise timeout
//   WAIT_HI | waiting for busy to rise; gives up after BUSY_TIMEOUT cycles
//   WAIT_LO | transmitter working; waiting for busy to fall
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH        = UART_TXQ_DEPTH,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic            clk,
    input  logic            reset,
    uart_tx_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LOAD = TW'(BUSY_TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(1);

    txq_state_t    r_state;
    txq_state_t    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [AW:0]   w_level_nxt;
    logic          r_full;
    logic          r_overflow;
    logic          r_send_req;
    byte_t         r_tx_data;
    byte_t         w_rd_data;
    logic [TW-1:0] r_tmo;
    logic          w_wr;
    logic          w_pop;
    logic          w_tmo_load;
    logic          w_tmo_dec;

    // A pop in the same cycle does not rescue a write: full is the registered view.
    assign w_wr = bus.wr_req & ~r_full;

    sync_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (w_wr),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.wr_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_tmo_load  = 1'b0;
        w_tmo_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level != '0 && !bus.busy) begin
                    w_pop       = 1'b1;
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                w_tmo_load  = 1'b1;
                w_state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (bus.busy)              w_state_nxt = WAIT_LO;
                else if (r_tmo == TMO_LAST) w_state_nxt = IDLE;
                else                        w_tmo_dec   = 1'b1;
            end
            WAIT_LO: begin
                if (!bus.busy) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_wr && !w_pop)      w_level_nxt = r_level + 1'b1;
        else if (!w_wr && w_pop) w_level_nxt = r_level - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_send_req <= 1'b0;
            r_tx_data  <= 8'h00;
            r_tmo      <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_tx_data <= w_rd_data;
            end
            r_send_req <= w_pop;
            r_level    <= w_level_nxt;
            r_full     <= (w_level_nxt == FULL_LVL);
            if (bus.wr_req && r_full) r_overflow <= 1'b1;
            else if (bus.ovf_clr)     r_overflow <= 1'b0;
            if (w_tmo_load)     r_tmo <= TMO_LOAD;
            else if (w_tmo_dec) r_tmo <= r_tmo - 1'b1;
        end
    end

    assign bus.full     = r_full;
    assign bus.level    = r_level;
    assign bus.overflow = r_overflow;
    assign bus.send_req = r_send_req;
    assign bus.tx_data  = r_tx_data;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (DEPTH=16, BUSY_TIMEOUT=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_uart_tx_fifo;
    localparam int DEPTH = 16;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   n;

    uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [7:0] b);
        bus.wr_req  = 1'b1;
        bus.wr_data = b;
        tick();
        bus.wr_req  = 1'b0;
    endtask

    // Returns the number of falling edges until send_req is seen, or -1 within 30 cycles.
    task automatic wait_req(output int cnt);
        cnt = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.send_req) begin
                cnt = i;
                break;
            end
        end
    endtask

    // Transmitter model: busy rises one cycle after the request and holds for 'hold' cycles.
    task automatic serve(input int hold);
        tick();
        chk("no_double_req", 32'(bus.send_req), 32'd0);
        bus.busy = 1'b1;
        repeat (hold) tick();
        bus.busy = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        reset       = 1'b0;
        bus.wr_req  = 1'b0;
        bus.wr_data = 8'h00;
        bus.ovf_clr = 1'b0;
        bus.busy    = 1'b0;
        repeat (2) tick();
        chk("rst_level",    32'(bus.level),    32'd0);
        chk("rst_full",     32'(bus.full),     32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_send_req", 32'(bus.send_req), 32'd0);
        chk("rst_tx_data",  32'(bus.tx_data),  32'h00);
        reset = 1'b1;
        tick();

        // 1: single byte latency
        push(8'h41);
        chk("t1_req_n1",   32'(bus.send_req), 32'd0);
        chk("t1_level_n1", 32'(bus.level),    32'd1);
        tick();
        chk("t1_req_n2",   32'(bus.send_req), 32'd1);
        chk("t1_data",     32'(bus.tx_data),  32'h41);
        chk("t1_level_n2", 32'(bus.level),    32'd0);
        repeat (10) tick();

        // 2: three back-to-back writes, busy held 10 cycles per byte
        bus.wr_req  = 1'b1;
        bus.wr_data = 8'h41;
        tick();
        bus.wr_data = 8'h42;
        chk("t2_req_e1", 32'(bus.send_req), 32'd0);
        tick();
        bus.wr_data = 8'h43;
        chk("t2_req_41",  32'(bus.send_req), 32'd1);
        chk("t2_data_41", 32'(bus.tx_data),  32'h41);
        tick();
        bus.wr_req = 1'b0;
        chk("t2_nodbl_41", 32'(bus.send_req), 32'd0);
        chk("t2_level",    32'(bus.level),    32'd2);
        bus.busy = 1'b1;
        repeat (10) tick();
        bus.busy = 1'b0;
        wait_req(n);
        chk("t2_gap_42",  32'(n),           32'd2);
        chk("t2_data_42", 32'(bus.tx_data), 32'h42);
        serve(10);
        wait_req(n);
        chk("t2_gap_43",  32'(n),           32'd2);
        chk("t2_data_43", 32'(bus.tx_data), 32'h43);
        serve(10);
        wait_req(n);
        chk("t2_no_4th",  32'(n),           32'hffff_ffff);

        // 3: fill while busy, overflow behaviour
        bus.busy = 1'b1;
        for (int i = 0; i < DEPTH; i++) push(8'hA0 + 8'(i));
        chk("t3_level_full", 32'(bus.level),    32'd16);
        chk("t3_full",       32'(bus.full),     32'd1);
        chk("t3_ovf_pre",    32'(bus.overflow), 32'd0);
        push(8'hB0);
        chk("t3_ovf_set",    32'(bus.overflow), 32'd1);
        chk("t3_level_drop", 32'(bus.level),    32'd16);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t3_ovf_clr",    32'(bus.overflow), 32'd0);
        bus.ovf_clr = 1'b1;
        push(8'hB1);
        bus.ovf_clr = 1'b0;
        chk("t3_set_wins",   32'(bus.overflow), 32'd1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        chk("t3_ovf_clr2",   32'(bus.overflow), 32'd0);
        bus.busy = 1'b0;
        push(8'hC0);
        chk("t3_pop_req",    32'(bus.send_req), 32'd1);
        chk("t3_pop_data",   32'(bus.tx_data),  32'hA0);
        chk("t3_pop_level",  32'(bus.level),    32'd15);
        chk("t3_pop_full",   32'(bus.full),     32'd0);
        chk("t3_pop_ovf",    32'(bus.overflow), 32'd1);
        reset = 1'b0;
        #1;
        chk("t3_rst_req",   32'(bus.send_req), 32'd0);
        chk("t3_rst_level", 32'(bus.level),    32'd0);
        chk("t3_rst_full",  32'(bus.full),     32'd0);
        chk("t3_rst_ovf",   32'(bus.overflow), 32'd0);
        chk("t3_rst_data",  32'(bus.tx_data),  32'h00);
        tick();
        reset = 1'b1;
        tick();

        // 4: three fill/drain rounds so both pointers wrap
        for (int r = 0; r < 3; r++) begin
            bus.busy = 1'b1;
            for (int i = 0; i < DEPTH; i++) push(8'(r * DEPTH + i));
            chk("t4_full", 32'(bus.full), 32'd1);
            bus.busy = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                wait_req(n);
                chk("t4_gap",  32'(n),           (i == 0) ? 32'd1 : 32'd2);
                chk("t4_data", 32'(bus.tx_data), 32'(r * DEPTH + i));
                tick();
                bus.busy = 1'b1;
                tick();
                bus.busy = 1'b0;
            end
            tick();
        end
        chk("t4_ovf",   32'(bus.overflow), 32'd0);
        chk("t4_level", 32'(bus.level),    32'd0);

        // 5: busy never rises, timeout releases each byte
        bus.wr_req  = 1'b1;
        bus.wr_data = 8'h55;
        tick();
        bus.wr_data = 8'h66;
        tick();
        bus.wr_req = 1'b0;
        chk("t5_req_55",  32'(bus.send_req), 32'd1);
        chk("t5_data_55", 32'(bus.tx_data),  32'h55);
        wait_req(n);
        chk("t5_tmo_gap", 32'(n),            32'd6);
        chk("t5_data_66", 32'(bus.tx_data),  32'h66);
        wait_req(n);
        chk("t5_no_more", 32'(n),            32'hffff_ffff);
        chk("t5_level",   32'(bus.level),    32'd0);

        // 6: reset while in WAIT_LO with 5 bytes queued
        bus.busy = 1'b1;
        for (int i = 0; i < 6; i++) push(8'h10 + 8'(i));
        bus.busy = 1'b0;
        wait_req(n);
        chk("t6_first_gap",  32'(n),           32'd1);
        chk("t6_first_data", 32'(bus.tx_data), 32'h10);
        tick();
        bus.busy = 1'b1;
        tick();
        chk("t6_level_pre", 32'(bus.level), 32'd5);
        reset = 1'b0;
        #1;
        chk("t6_rst_req",   32'(bus.send_req), 32'd0);
        chk("t6_rst_level", 32'(bus.level),    32'd0);
        chk("t6_rst_full",  32'(bus.full),     32'd0);
        tick();
        reset    = 1'b1;
        bus.busy = 1'b0;
        wait_req(n);
        chk("t6_no_req",    32'(n),            32'hffff_ffff);
        push(8'h77);
        chk("t6_new_n1",    32'(bus.send_req), 32'd0);
        tick();
        chk("t6_new_req",   32'(bus.send_req), 32'd1);
        chk("t6_new_data",  32'(bus.tx_data),  32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
